cpu_datapath: RTL and testbench



---
 rtl/cpu_datapath.sv | 111 +++++++++++
 tb/tb_cpu_datapath.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Register-transfer datapath for the four-instruction accumulator CPU: AR, PC, DR, AC, IR, bus and ALU.
// Optional feature macro: CPU_DP_ZFLAG_EN builds a registered accumulator-zero flag; otherwise zflag is tied to 0.
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              membus,
  input  logic              pcbus,
  input  logic              drbus,
  input  logic              arload,
  input  logic              pcload,
  input  logic              pcinc,
  input  logic              drload,
  input  logic              irload,
  input  logic              acload,
  input  logic              acinc,
  input  logic              alusel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              bus_err,
  output logic              zflag
);

  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [1:0]        ir_q, ir_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_res;
  logic              contention;

  // Fixed priority membus > drbus > pcbus; any overlap latches bus_err.
  always_comb begin
    bus = '0;
    if (membus)     bus = mem_rdata;
    else if (drbus) bus = dr_q;
    else if (pcbus) bus = DATA_W'(pc_q);
    contention = (membus & drbus) | (membus & pcbus) | (drbus & pcbus);
  end

  always_comb begin
    if (alusel) alu_res = ac_q & dr_q;
    else        alu_res = ac_q + dr_q;
  end

  always_comb begin
    ar_d      = ar_q;
    pc_d      = pc_q;
    dr_d      = dr_q;
    ac_d      = ac_q;
    ir_d      = ir_q;
    bus_err_d = bus_err_q | contention;
    if (arload) ar_d = bus[ADDR_W-1:0];
    if (pcload)     pc_d = bus[ADDR_W-1:0];
    else if (pcinc) pc_d = pc_q + 1'b1;
    if (drload) dr_d = bus;
    if (irload) ir_d = bus[DATA_W-1 -: 2];
    if (acload)     ac_d = alu_res;
    else if (acinc) ac_d = ac_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q      <= '0;
      pc_q      <= '0;
      dr_q      <= '0;
      ac_q      <= '0;
      ir_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      ar_q      <= ar_d;
      pc_q      <= pc_d;
      dr_q      <= dr_d;
      ac_q      <= ac_d;
      ir_q      <= ir_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef CPU_DP_ZFLAG_EN
  logic zflag_q, zflag_d;

  always_comb begin
    zflag_d = zflag_q;
    if (acload | acinc) zflag_d = (ac_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) zflag_q <= 1'b0;
    else     zflag_q <= zflag_d;
  end

  assign zflag = zflag_q;
`else
  assign zflag = 1'b0;
`endif

  assign mem_addr = ar_q;
  assign op       = ir_q;
  assign ac_out   = ac_q;
  assign pc_out   = pc_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: fetch sequence, ALU, increments, bus contention and reset.
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       membus, pcbus, drbus;
  logic       arload, pcload, pcinc, drload, irload, acload, acinc, alusel;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [1:0] op;
  logic [7:0] ac_out;
  logic [5:0] pc_out;
  logic       bus_err;
  logic       zflag;

  logic [7:0] mem [64];
  logic       ovr;
  logic [7:0] ovr_val;
  logic       zexp;

  int n_checks = 0;
  int n_fail   = 0;

  assign mem_rdata = ovr ? ovr_val : mem[mem_addr];

  always #5 clk = ~clk;

  cpu_datapath #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .membus(membus), .pcbus(pcbus), .drbus(drbus),
    .arload(arload), .pcload(pcload), .pcinc(pcinc), .drload(drload),
    .irload(irload), .acload(acload), .acinc(acinc), .alusel(alusel),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .op(op), .ac_out(ac_out), .pc_out(pc_out),
    .bus_err(bus_err), .zflag(zflag)
  );

  task automatic clear;
    rst = 0; membus = 0; pcbus = 0; drbus = 0;
    arload = 0; pcload = 0; pcinc = 0; drload = 0;
    irload = 0; acload = 0; acinc = 0; alusel = 0;
    ovr = 0; ovr_val = 8'h00;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    clear();
  endtask

  task automatic do_reset;
    clear();
    rst = 1;
    step();
  endtask

  task automatic load_dr(input logic [7:0] v);
    ovr = 1; ovr_val = v; membus = 1; drload = 1;
    step();
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if ({mem_addr, op, ac_out, pc_out, bus_err, zflag} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state got addr=%h op=%h ac=%h pc=%h err=%b z=%b want all 0",
               mem_addr, op, ac_out, pc_out, bus_err, zflag);
    end
  endtask

  task automatic test_fetch;
    do_reset();
    mem[0] = 8'h45;
    pcbus = 1; arload = 1; step();
    membus = 1; drload = 1; pcinc = 1; step();
    drbus = 1; irload = 1; arload = 1; step();
    n_checks++;
    if (mem_addr !== 6'h05) begin n_fail++; $display("FAIL fetch_ar got %h want 05", mem_addr); end
    n_checks++;
    if (op !== 2'b01) begin n_fail++; $display("FAIL fetch_op got %b want 01", op); end
    n_checks++;
    if (pc_out !== 6'd1) begin n_fail++; $display("FAIL fetch_pc got %0d want 1", pc_out); end
    n_checks++;
    if (bus_err !== 1'b0) begin n_fail++; $display("FAIL fetch_buserr got %b want 0", bus_err); end
    // DR is only visible through the ALU: AC=0 + DR.
    acload = 1; step();
    n_checks++;
    if (ac_out !== 8'h45) begin n_fail++; $display("FAIL fetch_dr got %h want 45", ac_out); end
  endtask

  task automatic test_alu;
    do_reset();
    load_dr(8'hF0);
    acload = 1; step();
    n_checks++;
    if (ac_out !== 8'hF0) begin n_fail++; $display("FAIL alu_preload got %h want f0", ac_out); end
    load_dr(8'h25);
    drbus = 1; acload = 1; alusel = 0; step();
    n_checks++;
    if (ac_out !== 8'h15) begin n_fail++; $display("FAIL alu_add got %h want 15", ac_out); end
    drbus = 1; acload = 1; alusel = 1; step();
    n_checks++;
    if (ac_out !== 8'h05) begin n_fail++; $display("FAIL alu_and got %h want 05", ac_out); end
  endtask

  task automatic test_acinc;
    do_reset();
    load_dr(8'hFF);
    acload = 1; step();
    n_checks++;
    if (ac_out !== 8'hFF || zflag !== 1'b0) begin
      n_fail++; $display("FAIL ac_ff got ac=%h z=%b want ff/0", ac_out, zflag);
    end
    acinc = 1; step();
`ifdef CPU_DP_ZFLAG_EN
    zexp = 1'b1;
`else
    zexp = 1'b0;
`endif
    n_checks++;
    if (ac_out !== 8'h00) begin n_fail++; $display("FAIL acinc_wrap got %h want 00", ac_out); end
    n_checks++;
    if (zflag !== zexp) begin n_fail++; $display("FAIL zflag_set got %b want %b", zflag, zexp); end
    load_dr(8'h03);
    n_checks++;
    if (zflag !== zexp) begin n_fail++; $display("FAIL zflag_hold got %b want %b", zflag, zexp); end
    acload = 1; acinc = 1; alusel = 0; step();
    n_checks++;
    if (ac_out !== 8'h03) begin n_fail++; $display("FAIL acload_wins got %h want 03", ac_out); end
    n_checks++;
    if (zflag !== 1'b0) begin n_fail++; $display("FAIL zflag_clear got %b want 0", zflag); end
  endtask

  task automatic test_pc;
    do_reset();
    load_dr(8'h3F);
    drbus = 1; pcload = 1; step();
    n_checks++;
    if (pc_out !== 6'd63) begin n_fail++; $display("FAIL pc_load63 got %0d want 63", pc_out); end
    pcinc = 1; step();
    n_checks++;
    if (pc_out !== 6'd0) begin n_fail++; $display("FAIL pc_wrap got %0d want 0", pc_out); end
    load_dr(8'h0A);
    drbus = 1; pcload = 1; step();
    load_dr(8'h87);
    drbus = 1; pcload = 1; pcinc = 1; step();
    n_checks++;
    if (pc_out !== 6'h07) begin n_fail++; $display("FAIL pcload_wins got %h want 07", pc_out); end
    n_checks++;
    if (bus_err !== 1'b0) begin n_fail++; $display("FAIL pc_buserr got %b want 0", bus_err); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    load_dr(8'h11);
    drbus = 1; drload = 1; step();
    drbus = 1; drload = 1; step();
    acload = 1; step();
    n_checks++;
    if (ac_out !== 8'h11) begin n_fail++; $display("FAIL dr_self_load got %h want 11", ac_out); end
    // Empty bus loads zero into DR.
    drload = 1; step();
    acload = 1; alusel = 1; step();
    n_checks++;
    if (ac_out !== 8'h00) begin n_fail++; $display("FAIL idle_bus got %h want 00", ac_out); end
  endtask

  task automatic test_bus_err;
    do_reset();
    ovr = 1; ovr_val = 8'h5A; membus = 1; pcbus = 1; drload = 1; step();
    n_checks++;
    if (bus_err !== 1'b1) begin n_fail++; $display("FAIL buserr_set got %b want 1", bus_err); end
    acload = 1; step();
    n_checks++;
    if (ac_out !== 8'h5A) begin n_fail++; $display("FAIL buserr_prio got %h want 5a", ac_out); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (bus_err !== 1'b1) begin
        n_fail++; $display("FAIL buserr_sticky cycle %0d got %b want 1", i, bus_err);
      end
    end
    do_reset();
    n_checks++;
    if (bus_err !== 1'b0) begin n_fail++; $display("FAIL buserr_clear got %b want 0", bus_err); end
  endtask

  task automatic test_midreset;
    do_reset();
    load_dr(8'h33);
    acload = 1; step();
    load_dr(8'h09);
    drbus = 1; pcload = 1; step();
    load_dr(8'hC0);
    drbus = 1; irload = 1; arload = 1; step();
    n_checks++;
    if (ac_out !== 8'h33 || pc_out !== 6'd9 || op !== 2'd3) begin
      n_fail++; $display("FAIL midreset_setup got ac=%h pc=%0d op=%0d want 33/9/3", ac_out, pc_out, op);
    end
    rst = 1; acinc = 1; pcinc = 1; step();
    n_checks++;
    if ({mem_addr, op, ac_out, pc_out, bus_err, zflag} !== 24'h0) begin
      n_fail++;
      $display("FAIL midreset got addr=%h op=%h ac=%h pc=%h err=%b z=%b want all 0",
               mem_addr, op, ac_out, pc_out, bus_err, zflag);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    clear();
    rst = 1;
    test_reset();
    test_fetch();
    test_alu();
    test_acinc();
    test_pc();
    test_back_to_back();
    test_bus_err();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
